// File: rtl/multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer
//   Iterative signed 32x32 multiply / divide unit with a HI/LO result pair.
//   A start in IDLE latches operand magnitudes and signs. RUN then performs
//   32 unsigned iterations, one per clock (shift-add or restoring divide).
//   FIX applies the sign correction and writes HI/LO on its exit edge.
//
// Ports
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-high, clears all state
//   start_mult   in   1  single-cycle multiply request (wins over start_div)
//   start_div    in   1  single-cycle divide request
//   op_a         in  32  multiplicand / dividend, sampled on the accepting edge
//   op_b         in  32  multiplier / divisor, sampled on the accepting edge
//   busy         out  1  high while in RUN or FIX
//   done         out  1  one-cycle end-of-operation pulse
//   hilo_write   out  1  one-cycle pulse when HI/LO are loaded
//   div_by_zero  out  1  one-cycle pulse for a divide with op_b == 0
//   hi           out 32  HI: product[63:32] or remainder
//   lo           out 32  LO: product[31:0] or quotient
//
// Handshake: start_* are plain request pulses with no ready. A request is
// accepted only on an edge where the FSM is in IDLE; requests on any other
// edge are dropped. Each accepted request yields exactly one done pulse.
// ---------------------------------------------------------------------------
module multdiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        hilo_write,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  count_q;
  logic [31:0] mag_a_q;
  logic [31:0] mag_b_q;
  logic        is_div_q;
  logic        res_neg_q;   // operand signs differ
  logic        dvd_neg_q;   // dividend negative (remainder sign)
  // Multiply: {product_hi, multiplier/product_lo}.
  // Divide:   {remainder, dividend shifting out / quotient shifting in}.
  logic [63:0] acc_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        hilo_write_q;
  logic        div_by_zero_q;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] add_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic [63:0] div_next;
  logic [63:0] prod_fixed;
  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;

  always_comb begin
    // 0x80000000 maps to itself, read as unsigned 2^31.
    abs_a = op_a[31] ? (~op_a + 32'd1) : op_a;
    abs_b = op_b[31] ? (~op_b + 32'd1) : op_b;

    // Shift-add step: conditionally add the multiplicand into the upper
    // half, keeping the carry, then shift the whole accumulator right.
    add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    mul_next = {add_sum, acc_q[31:1]};

    // Restoring step: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not go negative.
    rem_shift = {acc_q[63:32], acc_q[31]};
    trial     = rem_shift - {1'b0, mag_b_q};
    if (!trial[32]) begin
      div_next = {trial[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_next = {rem_shift[31:0], acc_q[30:0], 1'b0};
    end

    prod_fixed = res_neg_q ? (~acc_q + 64'd1) : acc_q;
    quot_fixed = res_neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fixed  = dvd_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= 5'd0;
      mag_a_q       <= 32'd0;
      mag_b_q       <= 32'd0;
      is_div_q      <= 1'b0;
      res_neg_q     <= 1'b0;
      dvd_neg_q     <= 1'b0;
      acc_q         <= 64'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hilo_write_q  <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      hilo_write_q  <= 1'b0;
      div_by_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_mult || start_div) begin
            if (!start_mult && (op_b == 32'd0)) begin
              // Divide by zero completes immediately; HI/LO untouched.
              done_q        <= 1'b1;
              div_by_zero_q <= 1'b1;
            end else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              count_q   <= 5'd0;
              is_div_q  <= !start_mult;
              mag_a_q   <= abs_a;
              mag_b_q   <= abs_b;
              res_neg_q <= op_a[31] ^ op_b[31];
              dvd_neg_q <= op_a[31];
              acc_q     <= start_mult ? {32'd0, abs_b} : {32'd0, abs_a};
            end
          end
        end
        RUN: begin
          acc_q   <= is_div_q ? div_next : mul_next;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q         <= is_div_q ? rem_fixed  : prod_fixed[63:32];
          lo_q         <= is_div_q ? quot_fixed : prod_fixed[31:0];
          done_q       <= 1'b1;
          hilo_write_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hilo_write  = hilo_write_q;
  assign div_by_zero = div_by_zero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multdiv_sequencer
//   Directed and random checks of multdiv_sequencer. Inputs are driven and
//   outputs sampled on the falling clock edge. Expected {hi, lo} values come
//   from a 64-bit signed reference model and are queued when a request is
//   driven, then popped when the DUT reports hilo_write.
// ---------------------------------------------------------------------------
module tb_multdiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        hilo_write;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] exp_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;

  multdiv_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start_mult  (start_mult),
    .start_div   (start_div),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .hilo_write  (hilo_write),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // -------------------------------------------------------------------------
  // Clock
  // -------------------------------------------------------------------------
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Reference model: returns {hi, lo}
  // -------------------------------------------------------------------------
  function automatic logic [63:0] model(input logic is_mult,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) begin
      res = 64'(sa * sb);
    end else begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Driver: issue one request and watch until done (bounded). edges is the
  // number of rising edges after the accepting edge at which done was seen.
  // Operands are scrambled after acceptance; pulse_at >= 0 pulses start_div
  // for one cycle at that point of the operation.
  // -------------------------------------------------------------------------
  task automatic run_op(input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at,
                        output int edges, output logic got_done,
                        output logic got_hw, output logic got_dbz,
                        output logic busy_ok, output int done_cnt,
                        output logic [31:0] got_hi, output logic [31:0] got_lo);
    @(negedge clk);
    start_mult = m;
    start_div  = d;
    op_a       = a;
    op_b       = b;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
    edges = 0; got_done = 1'b0; got_hw = 1'b0; got_dbz = 1'b0;
    busy_ok = 1'b1; done_cnt = 0; got_hi = '0; got_lo = '0;
    while (!got_done && edges < 60) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
        got_hw   = hilo_write;
        got_dbz  = div_by_zero;
        got_hi   = hi;
        got_lo   = lo;
        done_cnt++;
        if (busy !== 1'b0) busy_ok = 1'b0;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        @(negedge clk);
        edges++;
        start_div = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        if (edges == pulse_at) start_div = 1'b1;
      end
    end
    start_div = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenario tasks
  // -------------------------------------------------------------------------
  task automatic test_reset();
    start_mult = 1'b0; start_div = 1'b0; op_a = '0; op_b = '0;
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, hilo_write, div_by_zero} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, hilo_write, div_by_zero});
    end
    tests_run++;
    if ({hi, lo} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int edges; int dc; logic gd, hw, dz, bok; logic [31:0] h, l; logic [63:0] exp;
    exp_q.push_back(model(1'b1, 32'd7, 32'hFFFF_FFFD));
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1, edges, gd, hw, dz, bok, dc, h, l);
    tests_run++;
    if (gd !== 1'b1 || edges != 33) begin
      tests_failed++;
      $display("FAIL mult_latency: done=%b edges=%0d expected done=1 edges=33", gd, edges);
    end
    tests_run++;
    if (hw !== 1'b1 || dz !== 1'b0 || bok !== 1'b1 || dc != 1) begin
      tests_failed++;
      $display("FAIL mult_flags: hw=%b dbz=%b busy_ok=%b dones=%0d expected 1 0 1 1", hw, dz, bok, dc);
    end
    tests_run++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    if ({h, l} !== exp || exp !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      tests_failed++;
      $display("FAIL mult_result: got %h expected %h", {h, l}, exp);
    end
  endtask

  task automatic test_div();
    int edges; int dc; logic gd, hw, dz, bok; logic [31:0] h, l; logic [63:0] exp;
    exp_q.push_back(model(1'b0, 32'hFFFF_FFF9, 32'd2));
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, edges, gd, hw, dz, bok, dc, h, l);
    tests_run++;
    if (gd !== 1'b1 || edges != 33 || hw !== 1'b1 || dz !== 1'b0 || bok !== 1'b1 || dc != 1) begin
      tests_failed++;
      $display("FAIL div_handshake: done=%b edges=%0d hw=%b dbz=%b busy_ok=%b dones=%0d", gd, edges, hw, dz, bok, dc);
    end
    tests_run++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    if ({h, l} !== exp || exp !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      tests_failed++;
      $display("FAIL div_result: got %h expected %h", {h, l}, exp);
    end
  endtask

  task automatic test_div_by_zero();
    int edges; int dc; logic gd, hw, dz, bok; logic [31:0] h, l;
    run_op(1'b0, 1'b1, 32'd5, 32'd0, -1, edges, gd, hw, dz, bok, dc, h, l);
    tests_run++;
    if (gd !== 1'b1 || edges != 0) begin
      tests_failed++;
      $display("FAIL dbz_latency: done=%b edges=%0d expected done=1 edges=0", gd, edges);
    end
    tests_run++;
    if (dz !== 1'b1 || hw !== 1'b0 || bok !== 1'b1 || dc != 1) begin
      tests_failed++;
      $display("FAIL dbz_flags: dbz=%b hw=%b busy_ok=%b dones=%0d expected 1 0 1 1", dz, hw, bok, dc);
    end
    tests_run++;
    if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFD || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      tests_failed++;
      $display("FAIL dbz_hold: got %h/%h expected ffffffff_fffffffd", {h, l}, {hi, lo});
    end
  endtask

  task automatic test_collision();
    int edges; int dc; logic gd, hw, dz, bok; logic [31:0] h, l; logic [63:0] exp;
    exp_q.push_back(model(1'b1, 32'h8000_0000, 32'h8000_0000));
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 10, edges, gd, hw, dz, bok, dc, h, l);
    tests_run++;
    if (gd !== 1'b1 || edges != 33 || dc != 1 || hw !== 1'b1 || bok !== 1'b1) begin
      tests_failed++;
      $display("FAIL collision_handshake: done=%b edges=%0d dones=%0d hw=%b busy_ok=%b", gd, edges, dc, hw, bok);
    end
    tests_run++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    if ({h, l} !== exp || exp !== 64'h4000_0000_0000_0000) begin
      tests_failed++;
      $display("FAIL collision_result: got %h expected %h", {h, l}, exp);
    end
  endtask

  task automatic test_reset_mid();
    int edges; int dc; logic gd, hw, dz, bok; logic [31:0] h, l; logic [63:0] exp;
    int stray;
    @(negedge clk);
    start_mult = 1'b1; op_a = 32'd100; op_b = 32'd200;
    @(negedge clk);
    start_mult = 1'b0; op_a = $urandom; op_b = $urandom;
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, hilo_write, div_by_zero} !== 4'b0000 || {hi, lo} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: flags=%b hilo=%h expected 0000/0",
               {busy, done, hilo_write, div_by_zero}, {hi, lo});
    end
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1 || hilo_write === 1'b1) stray++;
    end
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || hilo_write === 1'b1 || busy === 1'b1) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_abort: got %0d stray cycles expected 0", stray);
    end
    exp_q.push_back(model(1'b1, 32'd3, 32'd4));
    run_op(1'b1, 1'b0, 32'd3, 32'd4, -1, edges, gd, hw, dz, bok, dc, h, l);
    tests_run++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    if (gd !== 1'b1 || edges != 33 || {h, l} !== exp || exp !== 64'd12) begin
      tests_failed++;
      $display("FAIL reset_mid_restart: done=%b edges=%0d got %h expected %h", gd, edges, {h, l}, exp);
    end
  endtask

  task automatic test_overflow_div();
    int edges; int dc; logic gd, hw, dz, bok; logic [31:0] h, l; logic [63:0] exp;
    exp_q.push_back(model(1'b0, 32'h8000_0000, 32'hFFFF_FFFF));
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, edges, gd, hw, dz, bok, dc, h, l);
    tests_run++;
    if (gd !== 1'b1 || edges != 33 || dz !== 1'b0 || hw !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_flags: done=%b edges=%0d dbz=%b hw=%b expected 1 33 0 1", gd, edges, dz, hw);
    end
    tests_run++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    if ({h, l} !== exp || exp !== 64'h0000_0000_8000_0000) begin
      tests_failed++;
      $display("FAIL ovf_result: got %h expected %h", {h, l}, exp);
    end
  endtask

  task automatic test_random();
    int edges; int dc; logic gd, hw, dz, bok; logic [31:0] h, l; logic [63:0] exp;
    logic m; logic [31:0] a, b; logic [63:0] prev; logic zero_div;
    for (int i = 0; i < 10; i++) begin
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (i == 3) b = 32'hFFFF_FFFF;
      if (i == 4) a = 32'h8000_0000;
      zero_div = !m && (b == 32'd0);
      prev = {hi, lo};
      if (!zero_div) exp_q.push_back(model(m, a, b));
      run_op(m, !m, a, b, -1, edges, gd, hw, dz, bok, dc, h, l);
      tests_run++;
      if (gd !== 1'b1 || edges != (zero_div ? 0 : 33) || dz !== zero_div ||
          hw !== !zero_div || bok !== 1'b1 || dc != 1) begin
        tests_failed++;
        $display("FAIL rand_handshake[%0d]: done=%b edges=%0d dbz=%b hw=%b busy_ok=%b dones=%0d",
                 i, gd, edges, dz, hw, bok, dc);
      end
      tests_run++;
      if (zero_div) exp = prev;
      else exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      if ({h, l} !== exp) begin
        tests_failed++;
        $display("FAIL rand_result[%0d]: mult=%b a=%h b=%h got %h expected %h", i, m, a, b, {h, l}, exp);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_collision();
    test_reset_mid();
    test_overflow_div();
    test_random();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-002 The ports SHALL be as follows:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start_mult  in  1  single-cycle request for a signed multiply of op_a by op_b.
- start_div  in  1  single-cycle request for a signed divide of op_a by op_b.
- op_a  in  32  multiplicand / dividend; sampled only on the accepting edge.
- op_b  in  32  multiplier / divisor; sampled only on the accepting edge.
- busy  out  1  high while the operation is in RUN or FIX.
- done  out  1  one-cycle pulse marking the end of an operation.
- hilo_write  out  1  one-cycle pulse, high when HI/LO are updated.
- div_by_zero  out  1  one-cycle pulse, high for a divide with op_b == 0.
- hi  out  32  HI result register.
- lo  out  32  LO result register.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN, FIX.
REQ-004 In IDLE, a start (start_mult or start_div) at edge E0 SHALL be accepted as follows:
- latch |op_a| and |op_b|, the result sign and the dividend sign;
- set a 5-bit iteration count to 0 and enter RUN.
REQ-005 When start_mult and start_div are both high in IDLE, start_mult SHALL win and start_div SHALL be dropped.
REQ-006 Starts asserted outside IDLE SHALL be ignored; there is no queuing and no effect on the current operation.
REQ-007 RUN SHALL perform one iteration per clock for exactly 32 clocks (count 0..31), then enter FIX:
- multiply: unsigned shift-add on the magnitudes into a 64-bit accumulator;
- divide: restoring division on the magnitudes, producing a 32-bit quotient and remainder.
REQ-008 FIX SHALL last one clock, apply the sign correction and return to IDLE:
- multiply: two's-complement negate the 64-bit product if the operand signs differ;
- divide: negate the quotient if the signs differ; negate the remainder if the dividend is negative (truncation toward zero).
REQ-009 On the FIX->IDLE edge E33, the block SHALL:
- load hi <= product[63:32] or remainder;
- load lo <= product[31:0] or quotient;
- pulse done and hilo_write together for one cycle.
REQ-010 A result SHALL therefore be visible on hi/lo, with done=1, in the 34th cycle after the start was sampled (33 edges after E0).
REQ-011 busy SHALL be 1 from the cycle after E0 through the cycle before done, and 0 while done=1.
REQ-012 For start_div with op_b == 0 at E0, the block SHALL:
- not enter RUN, and leave hi/lo unchanged;
- pulse div_by_zero=1 and done=1 in the cycle after E0, with hilo_write=0 and busy=0.
REQ-013 op_a = 0x80000000 divided by 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0; no exception is raised.
REQ-014 Magnitude of 0x80000000 SHALL be handled as unsigned 2^31, with no overflow in the 33-bit internal width.
REQ-015 hi/lo SHALL hold their value between hilo_write pulses; operand changes after E0 SHALL not affect the result.

Reset
REQ-016 Asserting reset SHALL immediately, without waiting for clk, set:
- state=IDLE, count=0;
- busy, done, hilo_write, div_by_zero = 0;
- hi, lo and all internal operand/accumulator registers = 0.
REQ-017 Reset during RUN or FIX SHALL abort the operation with no hilo_write.
REQ-018 After reset, the first start sampled at an edge with reset low SHALL be accepted normally.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Multiply: start_mult, op_a=7, op_b=0xFFFFFFFD -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done and hilo_write high in cycle 34 only.
- Divide: start_div, op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero: after the previous result, start_div op_a=5, op_b=0 -> next cycle div_by_zero=1, done=1, hilo_write=0; hi/lo unchanged (0xFFFFFFFF/0xFFFFFFFD).
- Start collisions: start_mult and start_div together (op_a=0x80000000, op_b=0x80000000) -> multiply runs, hi=0x40000000, lo=0; a start_div pulsed at cycle 10 is ignored, with exactly one done.
- Reset mid-operation: assert reset at RUN count=10 -> all outputs 0 asynchronously, no done; then start_mult op_a=3, op_b=4 -> lo=12, hi=0.
- Overflow divide: start_div op_a=0x80000000, op_b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
